pool_layer_scheduler: RTL and testbench
=======================================

# pool_layer_scheduler

Sequences one full convolution + max-pool layer over `NUM_FILTERS` filters. For each filter it starts the convolution engine, waits for it to finish, then starts the 2x2 max-pool engine. It also translates every pooled output into a write into the flatten/FC1 buffer at address `filter*OUT_DIM*OUT_DIM + pixel`. The block sits between the top-level inference controller and the conv/max-pool engines. It owns the level start/done handshakes, the filter index driving weight/bank select, and the flatten write port.

## Interface
- `NUM_FILTERS`, 8: filters per layer, range 1..16.
- `OUT_DIM`, 13: pooled map side; each filter yields `OUT_DIM*OUT_DIM` (169) outputs.
- `TIMEOUT`, 8191: maximum cycles allowed in either run phase before the block flags an error.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `layer_start`  in  1  level; sampled only in IDLE.
- `conv_start`  out  1  level start to the conv engine.
- `conv_done`  in  1  level done from the conv engine; held until its start drops.
- `pool_start`  out  1  level start to the max-pool engine.
- `pool_done`  in  1  level done from the max-pool engine; held until its start drops.
- `pool_valid`  in  1  one-cycle strobe per pooled output.
- `pool_data`  in  8  pooled value accompanying `pool_valid`.
- `filter_idx`  out  4  current filter; drives weight ROM and feature-map bank select.
- `wr_en`  out  1  flatten buffer write strobe.
- `wr_addr`  out  11  flatten buffer address.
- `wr_data`  out  8  flatten buffer data.
- `busy`  out  1  high from accept until DONE or ERR.
- `layer_done`  out  1  level; high in DONE.
- `error`  out  1  level; high in ERR.

## Operation
- States: IDLE, CONV_RUN, CONV_REL, POOL_RUN, POOL_REL, NEXT, DONE, ERR.
- **IDLE:** all outputs are 0. On `layer_start=1`: clear `filter_idx`, `pix_cnt` and the timer, then go to CONV_RUN.
- **CONV_RUN:** `conv_start=1`. The timer increments every cycle.
  - On `conv_done=1`, go to CONV_REL.
  - If the timer reaches `TIMEOUT`, go to ERR.
- **CONV_REL:** `conv_start=0`. Wait for `conv_done=0`, then clear the timer and go to POOL_RUN. This release step is mandatory because the engines hold done until start drops.
- **POOL_RUN:** `pool_start=1`. Each `pool_valid` produces one registered flatten write:
  - `wr_en=1`;
  - `wr_addr = filter_idx*OUT_DIM*OUT_DIM + pix_cnt`;
  - `wr_data = pool_data`;
  - `pix_cnt` increments.
- **POOL_RUN exits:**
  - On `pool_done=1` with `pix_cnt == OUT_DIM*OUT_DIM`, go to POOL_REL.
  - On `pool_done=1` with any other count, go to ERR.
  - A `pool_valid` arriving when `pix_cnt == OUT_DIM*OUT_DIM` is an overflow: the write is suppressed and the state goes to ERR.
  - If the timer reaches `TIMEOUT`, go to ERR.
- **POOL_REL:** `pool_start=0`. Wait for `pool_done=0`, then go to NEXT.
- **NEXT:**
  - If `filter_idx == NUM_FILTERS-1`, go to DONE.
  - Otherwise increment `filter_idx`, clear `pix_cnt` and the timer, and go to CONV_RUN.
- **DONE:** `layer_done=1` and `busy=0`. Return to IDLE when `layer_start=0`.
- **ERR:** `error=1`, `busy=0`, and both starts are 0. Return to IDLE only when `layer_start=0`. This clears `error`.
- `pool_valid` outside POOL_RUN is ignored.
- Address arithmetic:
  - The product `filter_idx*OUT_DIM*OUT_DIM` is computed at full width.
  - For the maximum, 15*169+168 = 2703, the product exceeds 11 bits, so `wr_addr` is truncated.
  - Configurations are legal only if `NUM_FILTERS*OUT_DIM*OUT_DIM <= 2048`. The default (1352) complies.

## Timing
- All outputs are registered.
- Reset (`rst_n=0`, asynchronous) forces IDLE and sets every output, `filter_idx`, `pix_cnt` and the timer to 0. This applies mid-layer as well: the starts drop immediately and no write is generated.
- `layer_start` is seen high in IDLE at edge N. Then `conv_start` and `busy` are 1 after edge N.
- `conv_done` is seen high at edge M. Then `conv_start` is 0 after edge M.
- `conv_done` is seen low at edge K. Then `pool_start` is 1 after edge K.
- `pool_valid` is sampled at edge P. Then `wr_en` is 1 for exactly the cycle after edge P, with its address and data.
- `pool_valid` and `pool_done` high at the same edge: the write is performed and counted first, then the completion check uses the updated count.
- Minimum inter-filter overhead: CONV_REL ≥1 cycle, POOL_REL ≥1 cycle, NEXT 1 cycle.
- `filter_idx` changes only in NEXT, and never while a start is high.

## Test plan
- **Nominal layer:**
  - Stimulus: `NUM_FILTERS=2`, `OUT_DIM=13`. Engine models assert done 20 cycles after start. The pool model emits 169 valids with `pool_data` = pixel index (low 8 bits) and releases done one cycle after start drops.
  - Required response: 338 writes, addresses 0..337 contiguous. The first write of filter 1 has `wr_addr=169`. `layer_done` rises; `error` stays 0.
- **Handshake release:**
  - Stimulus: the pool model holds `pool_done` high for 5 cycles after `pool_start` falls.
  - Required response: the scheduler stays in POOL_REL for those 5 cycles. The next `conv_start` rises exactly 2 cycles after `pool_done` falls (POOL_REL→NEXT→CONV_RUN).
- **Short count:**
  - Stimulus: the pool model emits 168 valids, then done.
  - Required response: `error=1`, `busy=0`, no further starts. Dropping `layer_start` returns to IDLE with `error=0`.
- **Timeout:**
  - Stimulus: `TIMEOUT=100`, and the conv model never asserts done.
  - Required response: `error` rises after 100 cycles in CONV_RUN, and `conv_start` falls.
- **Simultaneous last valid and done:**
  - Stimulus: the 169th `pool_valid` coincides with `pool_done`.
  - Required response: the write goes to address `filter*169+168`, with no error.
- **Reset mid-pool:**
  - Stimulus: pull `rst_n` low after 50 valids of filter 1.
  - Required response: all outputs are 0 immediately. After release with `layer_start=1`, the next write is at `wr_addr=0`.

Source files
------------

// File: rtl/pool_layer_scheduler.sv
// pool_layer_scheduler
// Steps one conv + 2x2 max-pool layer across NUM_FILTERS filters. For each
// filter it runs the conv engine, then the pool engine. Both engines use a
// level start/done handshake. Every pooled output becomes one write into the
// flatten buffer at filter*OUT_DIM*OUT_DIM + pixel.
module pool_layer_scheduler #(
    parameter int NUM_FILTERS = 8,
    parameter int OUT_DIM     = 13,
    parameter int TIMEOUT     = 8191
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        layer_start,
    output logic        conv_start,
    input  logic        conv_done,
    output logic        pool_start,
    input  logic        pool_done,
    input  logic        pool_valid,
    input  logic [7:0]  pool_data,
    output logic [3:0]  filter_idx,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        layer_done,
    output logic        error
);

    localparam int TOTAL = OUT_DIM * OUT_DIM;
    localparam int PW    = $clog2(TOTAL + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [PW-1:0] TOTAL_C   = PW'(TOTAL);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);
    localparam logic [3:0]    LAST_F    = 4'(NUM_FILTERS - 1);

    // Output flag bundle: {conv_start, pool_start, busy, layer_done, error}
    localparam logic [4:0] F_IDLE = 5'b00000;
    localparam logic [4:0] F_CONV = 5'b10100;
    localparam logic [4:0] F_WAIT = 5'b00100;
    localparam logic [4:0] F_POOL = 5'b01100;
    localparam logic [4:0] F_DONE = 5'b00010;
    localparam logic [4:0] F_ERR  = 5'b00001;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CONV_RUN = 3'd1,
        S_CONV_REL = 3'd2,
        S_POOL_RUN = 3'd3,
        S_POOL_REL = 3'd4,
        S_NEXT     = 3'd5,
        S_DONE     = 3'd6,
        S_ERR      = 3'd7
    } state_t;

    state_t         state_r;
    logic [4:0]     flags_r;
    logic [3:0]     filter_idx_r;
    logic [PW-1:0]  pix_cnt_r;
    logic [TW-1:0]  timer_r;
    logic           wr_en_r;
    logic [10:0]    wr_addr_r;
    logic [7:0]     wr_data_r;

    logic           pix_full_s;
    logic           wr_ok_s;
    logic           ovf_s;
    logic           timer_hit_s;
    logic [PW-1:0]  cnt_inc_s;
    logic [31:0]    addr_full_s;
    logic           addr_unused_s;

    // Pool-run datapath: write qualification, updated count, full-width address, timer limit
    always_comb begin
        pix_full_s  = (pix_cnt_r == TOTAL_C);
        wr_ok_s     = pool_valid & ~pix_full_s;
        ovf_s       = pool_valid & pix_full_s;
        cnt_inc_s   = pix_cnt_r + PW'(wr_ok_s);
        timer_hit_s = ((timer_r + TW'(1)) == TIMEOUT_C);
        addr_full_s = (32'(filter_idx_r) * 32'(TOTAL)) + 32'(pix_cnt_r);
    end

    // Product bits above the 11-bit buffer address are intentionally dropped
    assign addr_unused_s = ^addr_full_s[31:11];

    // Layer sequencing FSM with registered handshake, status and flatten-write outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            flags_r      <= F_IDLE;
            filter_idx_r <= 4'd0;
            pix_cnt_r    <= {PW{1'b0}};
            timer_r      <= {TW{1'b0}};
            wr_en_r      <= 1'b0;
            wr_addr_r    <= 11'd0;
            wr_data_r    <= 8'd0;
        end else begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= 11'd0;
            wr_data_r <= 8'd0;
            case (state_r)
                S_IDLE: begin
                    filter_idx_r <= 4'd0;
                    pix_cnt_r    <= {PW{1'b0}};
                    timer_r      <= {TW{1'b0}};
                    if (layer_start) begin
                        state_r <= S_CONV_RUN;
                        flags_r <= F_CONV;
                    end else begin
                        flags_r <= F_IDLE;
                    end
                end
                S_CONV_RUN: begin
                    timer_r <= timer_r + TW'(1);
                    if (conv_done) begin
                        state_r <= S_CONV_REL;
                        flags_r <= F_WAIT;
                    end else if (timer_hit_s) begin
                        state_r <= S_ERR;
                        flags_r <= F_ERR;
                    end else begin
                        flags_r <= F_CONV;
                    end
                end
                S_CONV_REL: begin
                    // The engine holds done until it sees start low
                    if (!conv_done) begin
                        timer_r <= {TW{1'b0}};
                        state_r <= S_POOL_RUN;
                        flags_r <= F_POOL;
                    end else begin
                        flags_r <= F_WAIT;
                    end
                end
                S_POOL_RUN: begin
                    timer_r   <= timer_r + TW'(1);
                    pix_cnt_r <= cnt_inc_s;
                    wr_en_r   <= wr_ok_s;
                    if (wr_ok_s) begin
                        wr_addr_r <= addr_full_s[10:0];
                        wr_data_r <= pool_data;
                    end else begin
                        wr_data_r <= 8'd0;
                    end
                    // Completion check uses the count including a same-cycle write
                    if (ovf_s) begin
                        state_r <= S_ERR;
                        flags_r <= F_ERR;
                    end else if (pool_done) begin
                        if (cnt_inc_s == TOTAL_C) begin
                            state_r <= S_POOL_REL;
                            flags_r <= F_WAIT;
                        end else begin
                            state_r <= S_ERR;
                            flags_r <= F_ERR;
                        end
                    end else if (timer_hit_s) begin
                        state_r <= S_ERR;
                        flags_r <= F_ERR;
                    end else begin
                        flags_r <= F_POOL;
                    end
                end
                S_POOL_REL: begin
                    if (!pool_done) begin
                        state_r <= S_NEXT;
                    end else begin
                        state_r <= S_POOL_REL;
                    end
                    flags_r <= F_WAIT;
                end
                S_NEXT: begin
                    if (filter_idx_r == LAST_F) begin
                        state_r <= S_DONE;
                        flags_r <= F_DONE;
                    end else begin
                        filter_idx_r <= filter_idx_r + 4'd1;
                        pix_cnt_r    <= {PW{1'b0}};
                        timer_r      <= {TW{1'b0}};
                        state_r      <= S_CONV_RUN;
                        flags_r      <= F_CONV;
                    end
                end
                S_DONE: begin
                    if (!layer_start) begin
                        state_r      <= S_IDLE;
                        flags_r      <= F_IDLE;
                        filter_idx_r <= 4'd0;
                    end else begin
                        flags_r <= F_DONE;
                    end
                end
                S_ERR: begin
                    if (!layer_start) begin
                        state_r      <= S_IDLE;
                        flags_r      <= F_IDLE;
                        filter_idx_r <= 4'd0;
                    end else begin
                        flags_r <= F_ERR;
                    end
                end
                default: begin
                    state_r <= S_ERR;
                    flags_r <= F_ERR;
                end
            endcase
        end
    end

    assign conv_start = flags_r[4];
    assign pool_start = flags_r[3];
    assign busy       = flags_r[2];
    assign layer_done = flags_r[1];
    assign error      = flags_r[0];
    assign filter_idx = filter_idx_r;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;

endmodule

// File: tb/tb_pool_layer_scheduler.sv
// Directed bench for pool_layer_scheduler: behavioural conv/pool engine models,
// a queue of expected flatten writes, and a table of layer scenarios.
module tb_pool_layer_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        layer_start = 1'b0;
    logic        conv_start, pool_start;
    logic        conv_done = 1'b0, pool_done = 1'b0, pool_valid = 1'b0;
    logic [7:0]  pool_data = 8'd0;
    logic [3:0]  filter_idx;
    logic        wr_en, busy, layer_done, error;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;

    // second instance with a short timeout; its engines never respond
    logic        t_layer_start = 1'b0;
    logic        t_conv_start, t_pool_start, t_wr_en, t_busy, t_layer_done, t_error;
    logic [3:0]  t_filter_idx;
    logic [10:0] t_wr_addr;
    logic [7:0]  t_wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int exp_addr_q[$];
    int exp_data_q[$];
    int ea, ed;

    always #5 clk = ~clk;

    pool_layer_scheduler #(.NUM_FILTERS(2), .OUT_DIM(13), .TIMEOUT(8191)) dut (
        .clk(clk), .rst_n(rst_n), .layer_start(layer_start),
        .conv_start(conv_start), .conv_done(conv_done),
        .pool_start(pool_start), .pool_done(pool_done),
        .pool_valid(pool_valid), .pool_data(pool_data),
        .filter_idx(filter_idx), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .layer_done(layer_done), .error(error)
    );

    pool_layer_scheduler #(.NUM_FILTERS(2), .OUT_DIM(13), .TIMEOUT(100)) dut_t (
        .clk(clk), .rst_n(rst_n), .layer_start(t_layer_start),
        .conv_start(t_conv_start), .conv_done(1'b0),
        .pool_start(t_pool_start), .pool_done(1'b0),
        .pool_valid(1'b0), .pool_data(8'd0),
        .filter_idx(t_filter_idx), .wr_en(t_wr_en), .wr_addr(t_wr_addr), .wr_data(t_wr_data),
        .busy(t_busy), .layer_done(t_layer_done), .error(t_error)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int addr, input int data);
        exp_addr_q.push_back(addr);
        exp_data_q.push_back(data);
    endtask

    // Flatten-write monitor: every write must match the next expected address/data
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_cnt++;
            if (exp_addr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got wr_addr %0d, expected no write", wr_addr);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(ea));
                check("wr_data", 64'(wr_data), 64'(ed));
            end
        end
    end

    // Conv engine model: done 20 cycles after start, released one cycle after start drops
    task automatic conv_phase();
        int n = 0;
        while (conv_start !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("conv_start_seen", 64'(n < 100), 64'd1);
        repeat (20) step();
        conv_done = 1'b1;
        step();
        check("conv_start_drop", 64'(conv_start), 64'd0);
        conv_done = 1'b0;
        step();
        check("pool_start_rise", 64'(pool_start), 64'd1);
    endtask

    // Pool engine model: nv back-to-back valids with data = pixel index
    task automatic pool_phase(input int f, input int nv, input bit together);
        int n = 0;
        for (int k = 0; k < nv; k++) begin
            pool_valid = 1'b1;
            pool_data  = 8'(k);
            if (k < 169) push_exp(f * 169 + k, k % 256);
            if (together && k == nv - 1) pool_done = 1'b1;
            step();
        end
        pool_valid = 1'b0;
        pool_data  = 8'd0;
        if (!together) begin
            pool_done = 1'b1;
            step();
        end
        while (pool_start !== 1'b0 && n < 50) begin
            step();
            n++;
        end
        check("pool_start_drop", 64'(n < 50), 64'd1);
    endtask

    typedef struct {
        int nv;
        bit together;
        int hold;
        bit exp_err;
        int exp_writes;
    } vec_t;

    vec_t vecs [5];

    task automatic run_layer(input vec_t v);
        int n;
        wr_cnt = 0;
        layer_start = 1'b1;
        step();
        check("start_response", 64'({conv_start, busy}), 64'd3);
        for (int f = 0; f < 2; f++) begin
            conv_phase();
            check("filter_idx", 64'(filter_idx), 64'(f));
            pool_phase(f, v.nv, v.together);
            if (error === 1'b1) break;
            for (int h = 0; h < v.hold; h++) begin
                check("hold_in_pool_rel", 64'({conv_start, pool_start, busy}), 64'd1);
                step();
            end
            pool_done = 1'b0;
            if (f < 1) begin
                step();
                check("next_gap_1", 64'(conv_start), 64'd0);
                step();
                check("next_gap_2", 64'(conv_start), 64'd1);
            end
        end
        pool_done = 1'b0;
        if (v.exp_err) begin
            for (int i = 0; i < 5; i++) begin
                check("err_state", 64'({conv_start, pool_start, busy, error}), 64'd1);
                step();
            end
        end else begin
            n = 0;
            while (layer_done !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            check("layer_done", 64'({layer_done, busy, error}), 64'd4);
        end
        check("write_count", 64'(wr_cnt), 64'(v.exp_writes));
        check("exp_queue_empty", 64'(exp_addr_q.size()), 64'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        layer_start = 1'b0;
        step();
        check("back_to_idle", 64'({busy, layer_done, error, conv_start, pool_start, filter_idx}), 64'd0);
        step();
    endtask

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vecs[0] = '{169, 1'b0, 0, 1'b0, 338};   // nominal layer
        vecs[1] = '{169, 1'b1, 0, 1'b0, 338};   // last valid coincides with done
        vecs[2] = '{169, 1'b0, 5, 1'b0, 338};   // done held 5 cycles after start drops
        vecs[3] = '{168, 1'b0, 0, 1'b1, 168};   // short count
        vecs[4] = '{170, 1'b0, 0, 1'b1, 169};   // overflow valid suppressed

        step();
        step();
        check("reset_state", 64'({conv_start, pool_start, busy, layer_done, error, wr_en,
                                  wr_addr, wr_data, filter_idx}), 64'd0);
        rst_n = 1'b1;
        step();
        check("idle_state", 64'({conv_start, pool_start, busy, layer_done, error, wr_en}), 64'd0);

        for (int i = 0; i < 5; i++) begin
            run_layer(vecs[i]);
        end

        // Timeout: conv engine never answers, limit 100 cycles
        t_layer_start = 1'b1;
        step();
        check("t_start", 64'({t_conv_start, t_busy}), 64'd3);
        n = 0;
        while (t_error !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        check("t_cycles_to_error", 64'(n), 64'd100);
        check("t_err_state", 64'({t_conv_start, t_pool_start, t_busy, t_error}), 64'd1);
        t_layer_start = 1'b0;
        step();
        check("t_err_cleared", 64'({t_error, t_busy}), 64'd0);

        // Reset in the middle of filter 1 pooling
        wr_cnt = 0;
        layer_start = 1'b1;
        step();
        conv_phase();
        pool_phase(0, 169, 1'b0);
        pool_done = 1'b0;
        step();
        step();
        conv_phase();
        for (int k = 0; k < 50; k++) begin
            pool_valid = 1'b1;
            pool_data  = 8'(k);
            push_exp(169 + k, k);
            step();
        end
        pool_valid = 1'b0;
        step();
        check("pre_reset_writes", 64'(wr_cnt), 64'd219);
        rst_n = 1'b0;
        #1;
        check("reset_mid_pool", 64'({conv_start, pool_start, busy, layer_done, error, wr_en,
                                     wr_addr, wr_data, filter_idx}), 64'd0);
        layer_start = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        layer_start = 1'b1;
        step();
        conv_phase();
        pool_valid = 1'b1;
        pool_data  = 8'd77;
        push_exp(0, 77);
        step();
        pool_valid = 1'b0;
        step();
        check("post_reset_write", 64'(wr_cnt), 64'd220);
        check("post_reset_queue", 64'(exp_addr_q.size()), 64'd0);
        rst_n = 1'b0;
        layer_start = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
